mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS CPU.
- Consumes the EX/MEM register outputs and runs the data-memory load/store over a req/ack handshake.
- Stalls upstream stages while a memory access is outstanding.
- Drives the MEM/WB pipeline register that feeds write-back.

Parameters:
ACK_TIMEOUT, 16, max cycles in BUSY waiting for dmem_ack before abort
TO_W, 5, width of timeout counter (must hold ACK_TIMEOUT)

Ports:
clk  in  1  pipeline clock, all state on posedge
rst  in  1  synchronous active-high reset
Control_in  in  4  [3]RegWrite [2]MemtoReg [1]MemRead [0]MemWrite
ALU_in  in  32  ALU result / memory byte address
RtData_in  in  32  store data
Rt_Rd_Addr_in  in  5  destination register
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1=store, 0=load
dmem_addr  out  32  word-aligned address
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid with dmem_ack
dmem_ack  in  1  one-cycle completion pulse
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
mem_err  out  1  one-cycle pulse: misaligned, illegal, or timeout
RegWrite_out  out  1  MEM/WB RegWrite
MemtoReg_out  out  1  MEM/WB MemtoReg
ReadData_out  out  32  MEM/WB load data
ALU_out  out  32  MEM/WB ALU result
Rt_Rd_Addr_out  out  5  MEM/WB destination

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0.
- memop = MemRead | MemWrite.
- FSM states: IDLE, BUSY.
- IDLE, memop = 0:
  - no stall.
  - MEM/WB loads Control[3:2], ALU_in, Rt_Rd_Addr_in; ReadData_out holds.
  - Latency 1 cycle.
- IDLE, memop = 1, legal:
  - Legal means exactly one of MemRead/MemWrite set and ALU_in[1:0] = 0.
  - Register dmem_addr = ALU_in, dmem_wdata = RtData_in, dmem_we = MemWrite; set dmem_req; go to BUSY.
  - stall = 1 combinationally.
  - MEM/WB loads bubble: RegWrite_out = 0, MemtoReg_out = 0, other fields hold.
- IDLE, memop = 1, illegal (both bits set, or misaligned):
  - No request; mem_err pulses next cycle.
  - MEM/WB loads bubble; no stall; instruction retired.
- BUSY, no ack:
  - stall = 1; dmem_req/addr/we/wdata held stable.
  - Counter increments; MEM/WB loads bubble.
- BUSY, dmem_ack = 1:
  - stall = 0 this cycle so upstream advances.
  - MEM/WB loads Control_in[3:2], ALU_in, Rt_Rd_Addr_in; ReadData_out = dmem_rdata on loads, hold on stores.
  - dmem_req drops next cycle; counter cleared; go to IDLE.
  - Minimum memory-op latency: 2 cycles.
- BUSY, counter reaches ACK_TIMEOUT-1 without ack:
  - Drop req; mem_err pulse; MEM/WB bubble.
  - stall = 0; go to IDLE.
- dmem_ack in IDLE is ignored. Ack and timeout in the same cycle: ack wins.
- Upstream holds EX/MEM stable whenever stall = 1; Control_in etc. are sampled only in IDLE or on the ack cycle.
- rst mid-BUSY: dmem_req = 0 and state IDLE after the edge; an ack arriving afterwards is ignored.
- A store never writes a register, regardless of Control_in[3].

Decomposition:
- Package mips_pkg:
  - control bit indices CTL_REGWRITE = 3, CTL_MEMTOREG = 2, CTL_MEMREAD = 1, CTL_MEMWRITE = 0
  - state enum IDLE/BUSY
  - bubble constant
- Sub-module mem_wb_reg: the MEM/WB register with load and bubble inputs and synchronous reset.
- The FSM, handshake, and error logic stay in mem_stage.

Test Plan:
- ALU op, Control_in = 4'b1000, ALU_in = 0x1234, Rt_Rd_Addr_in = 5 -> next cycle RegWrite_out = 1, ALU_out = 0x1234, Rt_Rd_Addr_out = 5; stall never 1.
- Load, Control_in = 4'b1110, ALU_in = 0x40, ack 3 cycles after req with rdata = 0xDEADBEEF:
  - dmem_req high with addr 0x40, we = 0.
  - stall high until the ack cycle.
  - Then ReadData_out = 0xDEADBEEF, MemtoReg_out = 1, RegWrite_out = 1.
- Store, Control_in = 4'b0001, ALU_in = 0x80, RtData_in = 0xCAFEF00D, immediate ack -> dmem_we = 1, wdata = 0xCAFEF00D, one stall cycle, RegWrite_out = 0, ReadData_out unchanged.
- Misaligned load, ALU_in = 0x42 -> no dmem_req, mem_err pulse, RegWrite_out = 0, no stall.
- Load with no ack -> dmem_req held exactly ACK_TIMEOUT (16) cycles, then req drops, mem_err pulse, stall releases, bubble retired.
- rst asserted while BUSY, ack arriving 1 cycle later -> all outputs 0, dmem_req 0, the late ack causes no MEM/WB update.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-bit positions, MEM-stage FSM
// states and the write-back control bubble.
package mips_pkg;

  localparam int CTL_REGWRITE = 3;
  localparam int CTL_MEMTOREG = 2;
  localparam int CTL_MEMREAD  = 1;
  localparam int CTL_MEMWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctl_t;

  localparam wb_ctl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load captures a full instruction; a bubble clears
// only the write-back controls so the data fields keep their last values.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        rdata_load,
  input  wb_ctl_t     ctl_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rdata_in,
  input  logic [4:0]  rd_in,
  output wb_ctl_t     ctl_out,
  output logic [31:0] alu_out,
  output logic [31:0] rdata_out,
  output logic [4:0]  rd_out
);

  wb_ctl_t     ctl_d, ctl_q;
  logic [31:0] alu_d, alu_q;
  logic [31:0] rdata_d, rdata_q;
  logic [4:0]  rd_d, rd_q;

  always_comb begin
    ctl_d   = ctl_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    if (load) begin
      ctl_d = ctl_in;
      alu_d = alu_in;
      rd_d  = rd_in;
      if (rdata_load) rdata_d = rdata_in;
    end else if (bubble) begin
      ctl_d = WB_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q   <= WB_BUBBLE;
      alu_q   <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
    end else begin
      ctl_q   <= ctl_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
    end
  end

  assign ctl_out   = ctl_q;
  assign alu_out   = alu_q;
  assign rdata_out = rdata_q;
  assign rd_out    = rd_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues data-memory loads/stores, stalls
// upstream while an access is outstanding, and feeds the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Control_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] RtData_in,
  input  logic [4:0]  Rt_Rd_Addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        mem_err,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  Rt_Rd_Addr_out,
  output mem_state_e  state_dbg
);

  // Handshake: dmem_req rises with addr/we/wdata registered and all four stay
  // frozen until the single-cycle dmem_ack; req falls on the edge after ack.
  // dmem_rdata is only meaningful in the ack cycle. Acks seen in IDLE are dropped.

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  mem_state_e      state_d, state_q;
  logic [TO_W-1:0] cnt_d, cnt_q;
  logic            req_d, req_q;
  logic            we_d, we_q;
  logic [31:0]     addr_d, addr_q;
  logic [31:0]     wdata_d, wdata_q;
  logic            err_d, err_q;

  logic    mem_read, mem_write, memop, legal;
  logic    stall_c, wb_load, wb_bubble, wb_rdata_load;
  wb_ctl_t wb_ctl_in, wb_ctl_out;

  assign mem_read  = Control_in[CTL_MEMREAD];
  assign mem_write = Control_in[CTL_MEMWRITE];
  assign memop     = mem_read | mem_write;
  assign legal     = memop && (mem_read ^ mem_write) && is_word_aligned(ALU_in);

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    req_d                = req_q;
    we_d                 = we_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    err_d                = 1'b0;
    stall_c              = 1'b0;
    wb_load              = 1'b0;
    wb_bubble            = 1'b0;
    wb_rdata_load        = 1'b0;
    wb_ctl_in.reg_write  = Control_in[CTL_REGWRITE];
    wb_ctl_in.mem_to_reg = Control_in[CTL_MEMTOREG];

    case (state_q)
      IDLE: begin
        if (!memop) begin
          wb_load = 1'b1;
        end else if (legal) begin
          stall_c   = 1'b1;
          req_d     = 1'b1;
          we_d      = mem_write;
          addr_d    = ALU_in;
          wdata_d   = RtData_in;
          cnt_d     = '0;
          wb_bubble = 1'b1;
          state_d   = BUSY;
        end else begin
          // Illegal access retires as a bubble with an error pulse, never stalls.
          err_d     = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          wb_load             = 1'b1;
          wb_rdata_load       = !we_q;
          wb_ctl_in.reg_write = Control_in[CTL_REGWRITE] & !we_q;
          req_d               = 1'b0;
          cnt_d               = '0;
          state_d             = IDLE;
        end else if (cnt_q == TO_LAST) begin
          req_d     = 1'b0;
          err_d     = 1'b1;
          wb_bubble = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          stall_c   = 1'b1;
          cnt_d     = cnt_q + TO_W'(1);
          wb_bubble = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .load       (wb_load),
    .bubble     (wb_bubble),
    .rdata_load (wb_rdata_load),
    .ctl_in     (wb_ctl_in),
    .alu_in     (ALU_in),
    .rdata_in   (dmem_rdata),
    .rd_in      (Rt_Rd_Addr_in),
    .ctl_out    (wb_ctl_out),
    .alu_out    (ALU_out),
    .rdata_out  (ReadData_out),
    .rd_out     (Rt_Rd_Addr_out)
  );

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign mem_err      = err_q;
  assign stall        = stall_c;
  assign RegWrite_out = wb_ctl_out.reg_write;
  assign MemtoReg_out = wb_ctl_out.mem_to_reg;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scenario tasks with a MEM/WB scoreboard queue.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Control_in;
  logic [31:0] ALU_in, RtData_in, dmem_rdata;
  logic [4:0]  Rt_Rd_Addr_in;
  logic        dmem_req, dmem_we, dmem_ack, stall, mem_err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] ReadData_out, ALU_out;
  logic [4:0]  Rt_Rd_Addr_out;
  mem_state_e  state_dbg;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .Control_in(Control_in), .ALU_in(ALU_in),
    .RtData_in(RtData_in), .Rt_Rd_Addr_in(Rt_Rd_Addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .mem_err(mem_err), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .ReadData_out(ReadData_out), .ALU_out(ALU_out),
    .Rt_Rd_Addr_out(Rt_Rd_Addr_out), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard word: {RegWrite, MemtoReg, ReadData, ALU, Rt_Rd_Addr}
  logic [70:0] exp_q[$];
  logic [70:0] exp_v;
  logic [70:0] got;
  assign got = {RegWrite_out, MemtoReg_out, ReadData_out, ALU_out, Rt_Rd_Addr_out};

  logic        m_rw, m_mr;
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    Control_in    = 4'b0000;
    ALU_in        = '0;
    RtData_in     = '0;
    Rt_Rd_Addr_in = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic push_exp(input logic rw, input logic mr, input logic [31:0] rdata,
                          input logic [31:0] alu, input logic [4:0] rd);
    exp_q.push_back({rw, mr, rdata, alu, rd});
    m_rw = rw; m_mr = mr; m_rdata = rdata; m_alu = alu; m_rd = rd;
  endtask

  task automatic push_bubble();
    push_exp(1'b0, 1'b0, m_rdata, m_alu, m_rd);
  endtask

  task automatic idle_cycle();
    set_idle();
    tick();
    m_rw = 1'b0; m_mr = 1'b0; m_alu = '0; m_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, mem_err, got} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wb=%h exp all zero",
               dmem_req, dmem_we, dmem_addr, got);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE);
    end
    rst = 1'b0;
    m_rw = 1'b0; m_mr = 1'b0; m_rdata = '0; m_alu = '0; m_rd = '0;
  endtask

  task automatic test_alu_op();
    Control_in = 4'b1000; ALU_in = 32'h1234; Rt_Rd_Addr_in = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall); end
    push_exp(1'b1, 1'b0, m_rdata, 32'h1234, 5'd5);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL alu_wb got %h exp %h", got, exp_v); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall_after got %b exp 0", stall); end
    idle_cycle();
  endtask

  task automatic test_load();
    Control_in = 4'b1110; ALU_in = 32'h40; Rt_Rd_Addr_in = 5'd7; RtData_in = 32'h5555;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_issue_stall got %b exp 1", stall); end
    push_bubble();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL load_issue_bubble got %h exp %h", got, exp_v); end
    checks++;
    if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL load_req got req=%b we=%b addr=%h exp 1 0 00000040", dmem_req, dmem_we, dmem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL load_wait_stall got %b exp 1", stall); end
      push_bubble();
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL load_wait_bubble got %h exp %h", got, exp_v); end
    end
    checks++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL load_req_held got req=%b addr=%h exp 1 00000040", dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL load_ack_stall got %b exp 0", stall); end
    push_exp(1'b1, 1'b1, 32'hDEADBEEF, 32'h40, 5'd7);
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL load_wb got %h exp %h", got, exp_v); end
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop got %b exp 0", dmem_req); end
    idle_cycle();
  endtask

  task automatic test_store();
    Control_in = 4'b0001; ALU_in = 32'h80; RtData_in = 32'hCAFEF00D; Rt_Rd_Addr_in = 5'd9;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL store_issue_stall got %b exp 1", stall); end
    push_bubble();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL store_issue_bubble got %h exp %h", got, exp_v); end
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h80, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h exp 1 1 00000080 cafef00d",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL store_ack_stall got %b exp 0", stall); end
    push_exp(1'b0, 1'b0, m_rdata, 32'h80, 5'd9);
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL store_wb got %h exp %h", got, exp_v); end
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL store_req_drop got %b exp 0", dmem_req); end
    idle_cycle();
  endtask

  task automatic test_illegal();
    logic [3:0]  ctl_tab [2];
    logic [31:0] addr_tab[2];
    ctl_tab[0] = 4'b1110; addr_tab[0] = 32'h42;
    ctl_tab[1] = 4'b1011; addr_tab[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      Control_in = ctl_tab[i]; ALU_in = addr_tab[i]; Rt_Rd_Addr_in = 5'd3; RtData_in = 32'h77;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL illegal_stall[%0d] got %b exp 0", i, stall); end
      push_bubble();
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL illegal_wb[%0d] got %h exp %h", i, got, exp_v); end
      checks++;
      if ({dmem_req, mem_err} !== 2'b01) begin
        errors++;
        $display("FAIL illegal_err[%0d] got req=%b err=%b exp 0 1", i, dmem_req, mem_err);
      end
      idle_cycle();
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse[%0d] got %b exp 0", i, mem_err); end
    end
  endtask

  task automatic test_timeout();
    int n;
    int stall_bad;
    Control_in = 4'b1110; ALU_in = 32'h200; Rt_Rd_Addr_in = 5'd12;
    #1;
    push_bubble();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL to_issue_bubble got %h exp %h", got, exp_v); end
    n = 0;
    stall_bad = 0;
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      // stall must hold for the first ACK_TIMEOUT-1 waiting cycles and release on the last
      if ((n < ACK_TIMEOUT) != (stall === 1'b1)) stall_bad++;
      tick();
    end
    push_bubble();
    checks++;
    if (n != ACK_TIMEOUT) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", n, ACK_TIMEOUT); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL to_stall got %0d bad cycles exp 0", stall_bad); end
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", mem_err); end
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL to_bubble got %h exp %h", got, exp_v); end
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL to_state got %0d exp %0d", state_dbg, IDLE); end
    idle_cycle();
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b exp 0", mem_err); end
  endtask

  task automatic test_reset_busy();
    Control_in = 4'b1110; ALU_in = 32'h300; Rt_Rd_Addr_in = 5'd4;
    tick();
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_req got %b exp 1", dmem_req); end
    rst = 1'b1;
    tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, got} !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL rb_outputs got req=%b addr=%h wb=%h state=%0d exp all zero, IDLE",
               dmem_req, dmem_addr, got, state_dbg);
    end
    rst = 1'b0;
    set_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    checks++;
    if ({dmem_req, RegWrite_out, MemtoReg_out, ReadData_out, mem_err} !== '0) begin
      errors++;
      $display("FAIL rb_late_ack got req=%b rw=%b mr=%b rdata=%h err=%b exp all zero",
               dmem_req, RegWrite_out, MemtoReg_out, ReadData_out, mem_err);
    end
    m_rw = 1'b0; m_mr = 1'b0; m_rdata = '0; m_alu = '0; m_rd = '0;
  endtask

  task automatic test_back_to_back();
    int          kind, dly;
    logic [31:0] addr, data, rdv;
    logic [4:0]  rd;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      dly  = $urandom_range(0, 3);
      addr = 32'($urandom_range(0, 1023)) << 2;
      data = $urandom;
      rdv  = $urandom;
      rd   = 5'($urandom_range(1, 31));
      ALU_in = addr; RtData_in = data; Rt_Rd_Addr_in = rd;
      if (kind == 0) begin
        Control_in = 4'b1100;
        push_exp(1'b1, 1'b1, m_rdata, addr, rd);
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b_alu[%0d] got %h exp %h", it, got, exp_v); end
      end else begin
        // a store carries RegWrite=1 here to show the stage refuses to write a register
        Control_in = (kind == 1) ? 4'b1110 : 4'b1001;
        push_bubble();
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v || {dmem_req, dmem_we, dmem_addr} !== {1'b1, kind == 2, addr}) begin
          errors++;
          $display("FAIL b2b_issue[%0d] got wb=%h req=%b we=%b addr=%h exp wb=%h req=1 we=%0d addr=%h",
                   it, got, dmem_req, dmem_we, dmem_addr, exp_v, kind == 2, addr);
        end
        repeat (dly) tick();
        dmem_ack = 1'b1; dmem_rdata = rdv;
        if (kind == 1) push_exp(1'b1, 1'b1, rdv, addr, rd);
        else           push_exp(1'b0, 1'b0, m_rdata, addr, rd);
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL b2b_mem[%0d] got %h exp %h", it, got, exp_v); end
      end
    end
    idle_cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_illegal();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
